mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Bus initiator for the flip-flop `memory` block. It drives that block's address, mode and write data, and captures its registered read data.
- Client side is a valid/ready request channel: single-word write, or read burst of 1..2^LEN_W-1 words. Responses return on a valid/ready channel, one word at a time.
- Sits between the CPU load/store/fetch logic and `memory`. It is the only agent that drives the memory interface.

Parameters:
- LEN_W, 4: width of `req_len`; maximum burst is 2^LEN_W-1 words.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: initiator can accept a request (high only in IDLE).
- req_write, input, 1: 1 = write, 0 = read.
- req_addr, input, 32: word address.
- req_wdata, input, 32: write data.
- req_len, input, LEN_W: read burst length; 0 is treated as 1; ignored for writes.
- rsp_valid, output, 1: read word available.
- rsp_ready, input, 1: client accepts the read word.
- rsp_data, output, 32: read word.
- rsp_last, output, 1: final word of the burst; qualified by `rsp_valid`.
- wr_ack, output, 1: one-cycle pulse when a write completes.
- wr_err, output, 1: readback mismatch; valid with `wr_ack`; 0 unless MEM_READBACK_CHECK_EN.
- mem_address, output, 32: to memory `address_in`.
- mem_mode, output, 1: to memory `mode`; 1 = write, 0 = read.
- mem_wdata, output, 32: to memory `data_in`.
- mem_rdata, input, 32: from memory `data_out`; updated at the edge ending a read-mode cycle.

Behaviour:
- Reset values: `req_ready` 1, `rsp_valid` 0, `rsp_last` 0, `rsp_data` 0, `wr_ack` 0, `wr_err` 0, `mem_address` 0, `mem_mode` 0, `mem_wdata` 0. State is IDLE.
- All outputs are registered. `req_ready` is decoded from state == IDLE.
- `mem_mode` is 1 only in the WRITE state, so an idle initiator never corrupts memory. Idle read cycles are harmless.
- States: IDLE, WRITE, READ, CAPTURE, RESP (plus VRD and VCMP when the optional feature is enabled).
- IDLE, on `req_valid && req_ready` at edge E0:
  - Latch `req_addr` into `mem_address`.
  - Write: `mem_wdata` <= `req_wdata`, `mem_mode` <= 1, go to WRITE.
  - Read: `mem_mode` <= 0, remaining <= max(`req_len`, 1), go to READ.
- WRITE: memory stores the word at edge E1.
  - At E1: `mem_mode` <= 0, `wr_ack` <= 1 for one cycle, go to IDLE.
  - A new request is accepted no earlier than E2.
- READ: memory loads `mem_rdata` at the end-of-cycle edge. Go to CAPTURE.
- CAPTURE: `mem_rdata` is valid.
  - At the edge: `rsp_data` <= `mem_rdata`, `rsp_valid` <= 1, `rsp_last` <= (remaining == 1). Go to RESP.
  - First word is visible in the cycle after E2 (accept-to-valid latency is 3 edges).
- RESP: hold `rsp_data`, `rsp_valid` and `rsp_last` stable until `rsp_ready`. On the handshake edge H:
  - `rsp_valid` <= 0.
  - If last: go to IDLE.
  - Otherwise: `mem_address` <= `mem_address` + 1 (32-bit wrap, 0xFFFFFFFF -> 0), remaining -= 1, go to READ.
  - The next word is visible after H+2, so sustained throughput is 1 word per 3 cycles with `rsp_ready` tied high.
- Addresses at or above the memory's SIZE: no special handling. Reads return 0 from memory; writes are dropped by memory.
- Request inputs are sampled only on the accept edge; changes while busy are ignored.
- Async reset mid-operation: state returns to IDLE and `mem_mode` clears immediately.
  - A write whose edge has not yet occurred is not performed.
  - A partially delivered burst is abandoned; no `rsp_last` is issued.
- `rsp_ready` is ignored when `rsp_valid` is 0.

Optional Feature:
- MEM_READBACK_CHECK_EN defined:
  - After WRITE, the E1 edge sets `mem_mode` <= 0 with the same address and goes to VRD. The memory read occurs at E2.
  - VCMP compares `mem_rdata` with `mem_wdata`. At E3: `wr_ack` <= 1, `wr_err` <= (mismatch), go to IDLE.
  - Write latency is 3 edges. An out-of-range address with nonzero data reports `wr_err` = 1.
- Not defined: VRD and VCMP do not exist, `wr_ack` follows E1, and `wr_err` is constant 0.

Test Plan:
- Reset, then idle for 10 cycles -> `mem_mode` stays 0, `req_ready` = 1, `rsp_valid` = 0, `wr_ack` = 0.
- Write addr 5 = 0xDEADBEEF, then read addr 5 len 1 -> `wr_ack` 1 cycle after E1; `rsp_data` = 0xDEADBEEF with `rsp_last` = 1, 3 edges after the read accept.
- Preload words 0..3 as 0x1003c1e0, 0x40400000, 0x1003c1e1, 0x3f800000; read addr 0 len 4 with `rsp_ready` toggling randomly -> four words in order, each held stable until accepted, `rsp_last` only on the 4th.
- Read addr 0xFFFFFFFF len 2 -> `mem_address` wraps to 0; second word = mem[0]; first word = 0 (out of range).
- Assert reset during RESP of a len-3 burst, and separately during WRITE before E1 -> immediate IDLE, `rsp_valid` = 0, `mem_mode` = 0, target word unchanged.
- With MEM_READBACK_CHECK_EN: write addr 2 = 0x12345678 -> `wr_ack` at E3 with `wr_err` = 0. Write addr 1000 (>= SIZE 300) = 0x1 -> `wr_ack` with `wr_err` = 1.

Source files
------------

// File: rtl/mem_initiator.sv
// mem_initiator: valid/ready client front end that is the sole driver of the flip-flop `memory` block.
// Optional MEM_READBACK_CHECK_EN: each write is re-read and compared, mismatches reported on wr_err.
module mem_initiator #(
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [LEN_W-1:0] req_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_last,
  output logic             wr_ack,
  output logic             wr_err,
  output logic [31:0]      mem_address,
  output logic             mem_mode,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and payload stable until that edge, ready may change freely.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_RESP
`ifdef MEM_READBACK_CHECK_EN
    ,
    S_VRD,
    S_VCMP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [31:0]      mem_address_d, mem_wdata_d, rsp_data_d;
  logic             mem_mode_d, rsp_valid_d, rsp_last_d, wr_ack_d;
`ifdef MEM_READBACK_CHECK_EN
  logic             wr_err_d;
`endif

  assign req_ready = (state_q == S_IDLE);

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    mem_address_d = mem_address;
    mem_mode_d    = mem_mode;
    mem_wdata_d   = mem_wdata;
    rsp_data_d    = rsp_data;
    rsp_valid_d   = rsp_valid;
    rsp_last_d    = rsp_last;
    wr_ack_d      = 1'b0;
`ifdef MEM_READBACK_CHECK_EN
    wr_err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mem_address_d = req_addr;
          if (req_write) begin
            mem_wdata_d = req_wdata;
            mem_mode_d  = 1'b1;
            state_d     = S_WRITE;
          end else begin
            mem_mode_d  = 1'b0;
            remaining_d = (req_len == '0) ? LEN_W'(1) : req_len;
            state_d     = S_READ;
          end
        end
      end
      S_WRITE: begin
        // Memory stores the word on this edge; write mode never outlives one cycle.
        mem_mode_d = 1'b0;
`ifdef MEM_READBACK_CHECK_EN
        state_d    = S_VRD;
`else
        wr_ack_d   = 1'b1;
        state_d    = S_IDLE;
`endif
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        rsp_data_d  = mem_rdata;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (remaining_q == LEN_W'(1));
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (rsp_last) begin
            state_d = S_IDLE;
          end else begin
            mem_address_d = mem_address + 32'd1;
            remaining_d   = remaining_q - LEN_W'(1);
            state_d       = S_READ;
          end
        end
      end
`ifdef MEM_READBACK_CHECK_EN
      S_VRD: state_d = S_VCMP;
      S_VCMP: begin
        // Out-of-range addresses read back as 0, so nonzero data flags an error.
        wr_ack_d = 1'b1;
        wr_err_d = (mem_rdata != mem_wdata);
        state_d  = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      mem_address <= '0;
      mem_mode    <= 1'b0;
      mem_wdata   <= '0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      rsp_last    <= 1'b0;
      wr_ack      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      mem_address <= mem_address_d;
      mem_mode    <= mem_mode_d;
      mem_wdata   <= mem_wdata_d;
      rsp_data    <= rsp_data_d;
      rsp_valid   <= rsp_valid_d;
      rsp_last    <= rsp_last_d;
      wr_ack      <= wr_ack_d;
    end
  end

`ifdef MEM_READBACK_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wr_err <= 1'b0;
    else       wr_err <= wr_err_d;
  end
`else
  assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: directed plus randomized bench for mem_initiator against a behavioural
// flip-flop memory and a word-array reference model (honours MEM_READBACK_CHECK_EN).
module tb_mem_initiator;
  localparam int          LEN_W = 4;
  localparam logic [31:0] SIZE  = 32'd300;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_write;
  logic [31:0]      req_addr, req_wdata;
  logic [LEN_W-1:0] req_len;
  logic             rsp_valid, rsp_ready, rsp_last;
  logic [31:0]      rsp_data;
  logic             wr_ack, wr_err;
  logic [31:0]      mem_address, mem_wdata, mem_rdata;
  logic             mem_mode;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_initiator #(.LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .mem_address(mem_address), .mem_mode(mem_mode), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural flip-flop memory: write in write mode, registered read otherwise.
  logic [31:0] mem [0:299];
  always @(posedge clock) begin
    if (mem_mode) begin
      if (mem_address < SIZE) mem[mem_address] <= mem_wdata;
    end else begin
      mem_rdata <= (mem_address < SIZE) ? mem[mem_address] : 32'd0;
    end
  end

  // Reference model: what every word should hold given the writes issued.
  logic [31:0] ref_mem [0:299];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return (a < SIZE) ? ref_mem[a] : 32'd0;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    logic exp_err;
    @(negedge clock);
    check1("wr_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
    req_len = LEN_W'($urandom);
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    check1("wr_mode", mem_mode, 1'b1);
    check32("wr_addr", mem_address, addr);
    check1("wr_ready_busy", req_ready, 1'b0);
`ifdef MEM_READBACK_CHECK_EN
    repeat (2) begin
      @(posedge clock); #1;
      check1("wr_ack_early", wr_ack, 1'b0);
    end
    exp_err = (addr >= SIZE) && (data != 32'd0);
`else
    exp_err = 1'b0;
`endif
    @(posedge clock); #1;
    check1("wr_ack", wr_ack, 1'b1);
    check1("wr_err", wr_err, exp_err);
    check1("wr_mode_off", mem_mode, 1'b0);
    if (addr < SIZE) ref_mem[addr] = data;
    @(posedge clock); #1;
    check1("wr_ack_pulse", wr_ack, 1'b0);
    check1("wr_idle", req_ready, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [LEN_W-1:0] len, input bit rand_ready);
    int n, idx, cyc, last_hs;
    bit hs;
    n = (len == '0) ? 1 : int'(len);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_rd(addr + 32'(i)));
    @(negedge clock);
    check1("rd_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
    req_wdata = $urandom; rsp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = $urandom; req_len = LEN_W'($urandom);
    check1("rd_mode", mem_mode, 1'b0);
    check1("rd_valid_e0", rsp_valid, 1'b0);
    @(posedge clock); #1;
    check1("rd_valid_e1", rsp_valid, 1'b0);
    @(posedge clock); #1;
    check1("rd_valid_e2", rsp_valid, 1'b1);
    idx = 0; cyc = 0; last_hs = 0;
    while (idx < n && cyc < 60 * n + 20) begin
      if (rsp_valid) begin
        check32("rd_data", rsp_data, exp_q[0]);
        check1("rd_last", rsp_last, idx == n - 1);
      end
      @(negedge clock);
      rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = rsp_valid && rsp_ready;
      @(posedge clock); #1;
      cyc++;
      if (hs) begin
        if (!rand_ready && idx > 0) check32("rd_gap", 32'(cyc - last_hs), 32'd3);
        last_hs = cyc;
        void'(exp_q.pop_front());
        idx++;
      end
    end
    rsp_ready = 1'b0;
    check1("rd_timeout", idx >= n, 1'b1);
    exp_q.delete();
    check1("rd_done_idle", req_ready, 1'b1);
    check1("rd_done_valid", rsp_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] old7;
    int wait_cyc;
    for (int i = 0; i < 300; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem_rdata = 32'd0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_len = '0; rsp_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check1("rst_rsp_last", rsp_last, 1'b0);
    check32("rst_rsp_data", rsp_data, 32'd0);
    check1("rst_wr_ack", wr_ack, 1'b0);
    check1("rst_wr_err", wr_err, 1'b0);
    check32("rst_mem_address", mem_address, 32'd0);
    check1("rst_mem_mode", mem_mode, 1'b0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clock) reset = 1'b0;

    // Idle for 10 cycles
    repeat (10) begin
      @(posedge clock); #1;
      check1("idle_mode", mem_mode, 1'b0);
      check1("idle_ready", req_ready, 1'b1);
      check1("idle_valid", rsp_valid, 1'b0);
      check1("idle_ack", wr_ack, 1'b0);
    end

    // Write then read back a single word
    do_write(32'd5, 32'hDEADBEEF);
    do_read(32'd5, LEN_W'(1), 1'b0);

    // Four-word burst with random back-pressure
    do_write(32'd0, 32'h1003c1e0);
    do_write(32'd1, 32'h40400000);
    do_write(32'd2, 32'h1003c1e1);
    do_write(32'd3, 32'h3f800000);
    do_read(32'd0, LEN_W'(4), 1'b1);

    // Address wrap from the top of the space
    do_read(32'hFFFFFFFF, LEN_W'(2), 1'b0);
    check32("wrap_addr", mem_address, 32'd0);

    // Length 0 behaves as 1, maximum burst length
    do_read(32'd1, LEN_W'(0), 1'b0);
    do_read(32'd290, LEN_W'(15), 1'b0);

    // Readback-checked writes (wr_err expectation depends on build)
    do_write(32'd2, 32'h12345678);
    do_write(32'd1000, 32'h00000001);
    do_read(32'd2, LEN_W'(1), 1'b0);

    // Reset while a len-3 burst is holding its first word
    do_write(32'd10, $urandom);
    do_write(32'd11, $urandom);
    do_write(32'd12, $urandom);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd10; req_len = LEN_W'(3); rsp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    wait_cyc = 0;
    while (!rsp_valid && wait_cyc < 10) begin
      @(posedge clock); #1;
      wait_cyc++;
    end
    check1("rstb_reached_resp", rsp_valid, 1'b1);
    @(negedge clock) reset = 1'b1;
    #1;
    check1("rstb_valid", rsp_valid, 1'b0);
    check1("rstb_mode", mem_mode, 1'b0);
    check1("rstb_ready", req_ready, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
      check1("rstb_no_resume", rsp_valid, 1'b0);
      check1("rstb_no_last", rsp_last, 1'b0);
    end

    // Reset in the WRITE cycle before the storing edge
    do_write(32'd7, 32'hA5A5A5A5);
    old7 = ref_mem[7];
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd7; req_wdata = 32'h0BADF00D;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check1("rstw_mode_on", mem_mode, 1'b1);
    #2 reset = 1'b1;
    #1;
    check1("rstw_mode_off", mem_mode, 1'b0);
    check1("rstw_ready", req_ready, 1'b1);
    @(posedge clock); #1;
    check1("rstw_no_ack", wr_ack, 1'b0);
    @(negedge clock) reset = 1'b0;
    check32("rstw_ref_kept", ref_mem[7], old7);
    do_read(32'd7, LEN_W'(1), 1'b0);

    // Randomized writes (some out of range) and bursts
    repeat (20) do_write(32'($urandom_range(0, 320)), $urandom);
    repeat (10) do_read(32'($urandom_range(0, 310)), LEN_W'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
